// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier.
// Contents: XLEN, RV32M funct3[1:0] op encodings, and the sequencer state type.
package mul_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABS_A,
    ST_ABS_B,
    ST_CALC,
    ST_NEG_LO,
    ST_NEG_HI,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ksa_add.sv
// Kogge-Stone parallel-prefix adder with carry-in.
// Ports:
//   i_a, i_b  : W-bit operands
//   i_c0      : carry-in
//   o_sum     : W-bit sum
//   o_carry   : carry-out of the top bit
module ksa_add #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_c0,
  output logic [W-1:0] o_sum,
  output logic         o_carry
);

  localparam int LVL = $clog2(W);

  // Prefix tree is built on block-local variables so each level is a fresh
  // value rather than a self-referencing module signal.
  always_comb begin : prefix
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] gn;
    logic [W-1:0] pn;
    logic [W-1:0] p0;
    logic [W:0]   c;
    p0 = i_a ^ i_b;
    g  = i_a & i_b;
    p  = p0;
    for (int k = 0; k < LVL; k++) begin
      gn = g;
      pn = p;
      for (int i = (1 << k); i < W; i++) begin
        gn[i] = g[i] | (p[i] & g[i-(1<<k)]);
        pn[i] = p[i] & p[i-(1<<k)];
      end
      g = gn;
      p = pn;
    end
    // Carry-in folds in as a generate below bit 0.
    c[0] = i_c0;
    for (int i = 0; i < W; i++) begin
      c[i+1] = g[i] | (p[i] & i_c0);
    end
    o_sum   = p0 ^ c[W-1:0];
    o_carry = c[W];
  end

endmodule

// File: rtl/seq_mul_unit.sv
// Iterative 32x32 multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Signed operands are converted to magnitudes, multiplied by 32 shift-add
// steps, and the 64-bit product is negated back when the signs differ.
// All additions share one ksa_add instance through an operand mux.
//
// Ports:
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_valid, o_ready  : request handshake from issue (o_ready only in IDLE)
//   i_op, i_a, i_b    : funct3[1:0], rs1, rs2
//   i_flush           : abort in-flight operation (beats i_valid / i_ready)
//   o_valid, i_ready  : result handshake to writeback
//   o_result          : low word for MUL, high word otherwise
//   o_busy            : high in any state except IDLE
//
// Build option: define SEQ_MUL_ZERO_BYPASS_EN to send zero-operand requests
// straight from IDLE to DONE with a zero result.
//
// state     | meaning
// ----------+---------------------------------------------------
// IDLE      | waiting for a request, o_ready=1
// ABS_A     | a <= -a (signed negative multiplicand)
// ABS_B     | b <= -b (signed negative multiplier)
// CALC      | 32 shift-add steps of {hi,lo}
// NEG_LO    | lo <= ~lo + 1, carry saved in nc
// NEG_HI    | hi <= ~hi + nc
// DONE      | result held until writeback takes it
module seq_mul_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  import mul_pkg::*;

  if (XLEN != 32) begin : g_xlen_check
    $error("seq_mul_unit supports XLEN=32 only");
  end

  state_t          state;
  logic [1:0]      op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [4:0]      cnt_q;
  logic            neg_a_q;
  logic            neg_b_q;
  logic            nc_q;
  logic            neg_res;

  logic            req_neg_a;
  logic            req_neg_b;

  logic [XLEN-1:0] add_a;
  logic [XLEN-1:0] add_b;
  logic            add_c0;
  logic [XLEN-1:0] add_sum;
  logic            add_carry;

  assign req_neg_a = i_a[XLEN-1] & ((i_op == MUL_OP_MULH) | (i_op == MUL_OP_MULHSU));
  assign req_neg_b = i_b[XLEN-1] & (i_op == MUL_OP_MULH);
  assign neg_res   = neg_a_q ^ neg_b_q;

  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_c0 = 1'b0;
    case (state)
      ST_ABS_A: begin
        add_a  = ~a_q;
        add_c0 = 1'b1;
      end
      ST_ABS_B: begin
        add_a  = ~b_q;
        add_c0 = 1'b1;
      end
      ST_CALC: begin
        add_a = hi_q;
        add_b = lo_q[0] ? a_q : '0;
      end
      ST_NEG_LO: begin
        add_a  = ~lo_q;
        add_c0 = 1'b1;
      end
      ST_NEG_HI: begin
        add_a  = ~hi_q;
        add_c0 = nc_q;
      end
      default: ;
    endcase
  end

  ksa_add #(.W(XLEN)) u_ksa_add (
    .i_a     (add_a),
    .i_b     (add_b),
    .i_c0    (add_c0),
    .o_sum   (add_sum),
    .o_carry (add_carry)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      nc_q     <= 1'b0;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_busy   <= 1'b0;
      o_ready  <= 1'b1;
    end else if (i_flush) begin
      state   <= ST_IDLE;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_ready <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            op_q    <= i_op;
            a_q     <= i_a;
            b_q     <= i_b;
            hi_q    <= '0;
            lo_q    <= i_b;
            cnt_q   <= '0;
            nc_q    <= 1'b0;
            neg_a_q <= req_neg_a;
            neg_b_q <= req_neg_b;
            o_ready <= 1'b0;
            o_busy  <= 1'b1;
`ifdef SEQ_MUL_ZERO_BYPASS_EN
            if ((i_a == '0) || (i_b == '0)) begin
              state    <= ST_DONE;
              o_valid  <= 1'b1;
              o_result <= '0;
            end else
`endif
            if (req_neg_a)      state <= ST_ABS_A;
            else if (req_neg_b) state <= ST_ABS_B;
            else                state <= ST_CALC;
          end
        end
        ST_ABS_A: begin
          a_q   <= add_sum;
          state <= neg_b_q ? ST_ABS_B : ST_CALC;
        end
        ST_ABS_B: begin
          b_q   <= add_sum;
          lo_q  <= add_sum;
          state <= ST_CALC;
        end
        ST_CALC: begin
          hi_q  <= {add_carry, add_sum[XLEN-1:1]};
          lo_q  <= {add_sum[0], lo_q[XLEN-1:1]};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            if (neg_res) begin
              state <= ST_NEG_LO;
            end else begin
              state    <= ST_DONE;
              o_valid  <= 1'b1;
              // Capture the post-shift value being written this cycle.
              o_result <= (op_q == MUL_OP_MUL) ? {add_sum[0], lo_q[XLEN-1:1]}
                                               : {add_carry, add_sum[XLEN-1:1]};
            end
          end
        end
        ST_NEG_LO: begin
          lo_q  <= add_sum;
          nc_q  <= add_carry;
          state <= ST_NEG_HI;
        end
        ST_NEG_HI: begin
          hi_q     <= add_sum;
          state    <= ST_DONE;
          o_valid  <= 1'b1;
          o_result <= (op_q == MUL_OP_MUL) ? lo_q : add_sum;
        end
        ST_DONE: begin
          if (i_ready) begin
            state   <= ST_IDLE;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            o_ready <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_unit.sv
// Directed self-checking bench for seq_mul_unit with a result scoreboard.
module tb_seq_mul_unit;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_busy;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];

  seq_mul_unit #(.XLEN(32)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_flush  (i_flush),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_busy   (o_busy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] ae;
    logic [63:0] be;
    logic [63:0] p;
    ae = {32'b0, a};
    be = {32'b0, b};
    if (op == 2'b01 || op == 2'b10) ae = {{32{a[31]}}, a};
    if (op == 2'b01)                be = {{32{b[31]}}, b};
    p = ae * be;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    logic na;
    logic nb;
    na = a[31] & (op == 2'b01 || op == 2'b10);
    nb = b[31] & (op == 2'b01);
`ifdef SEQ_MUL_ZERO_BYPASS_EN
    if (a == 32'h0 || b == 32'h0) return 1;
`endif
    return 33 + int'(na) + int'(nb) + ((na ^ nb) ? 2 : 0);
  endfunction

  // Cycles counted from the accept edge; 1 means o_valid is up right after it.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!o_valid && cyc < 100) begin
      step();
      cyc++;
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    int          cyc;
    logic [31:0] exp;
    int          lat;
    check({tag, "_ready"}, o_ready, 1'b1);
    i_valid = 1'b1;
    i_op    = op;
    i_a     = a;
    i_b     = b;
    exp_q.push_back(model_res(op, a, b));
    lat_q.push_back(model_lat(op, a, b));
    step();
    i_valid = 1'b0;
    if (!o_valid) check({tag, "_busy"}, {o_busy, o_ready}, 2'b10);
    wait_valid(cyc);
    exp = exp_q.pop_front();
    lat = lat_q.pop_front();
    check({tag, "_lat"}, cyc, lat);
    check({tag, "_res"}, o_result, exp);
    // Stall writeback while a new request knocks on the door.
    for (int k = 0; k < hold; k++) begin
      i_valid = 1'b1;
      i_op    = 2'b11;
      i_a     = 32'h0000_0007;
      i_b     = 32'h0000_0009;
      step();
      check({tag, "_hold"}, {o_valid, o_ready, o_result}, {2'b10, exp});
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    check({tag, "_drain"}, {o_valid, o_ready, o_busy}, 3'b010);
  endtask

  initial begin
    int cyc;
    int seen;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_op    = 2'b00;
    i_a     = '0;
    i_b     = '0;
    i_flush = 1'b0;
    i_ready = 1'b0;
    step();
    step();
    check("rst_outs", {o_valid, o_busy, o_ready, o_result}, {3'b001, 32'h0});
    i_rst = 1'b0;
    step();
    check("idle_outs", {o_valid, o_busy, o_ready}, 3'b001);

    do_op("mulhu_ff",   2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op("mul_mix",    2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 0);
    do_op("mulh_m1x2",  2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    do_op("mulhsu_min", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("mulh_min2",  2'b01, 32'h8000_0000, 32'h8000_0000, 0);
    do_op("mulh_negb",  2'b01, 32'h0000_0003, 32'hFFFF_FFFB, 0);
    do_op("backpress",  2'b11, 32'hDEAD_BEEF, 32'hCAFE_F00D, 10);

    // Request presented together with flush must be refused.
    i_valid = 1'b1;
    i_flush = 1'b1;
    i_op    = 2'b11;
    i_a     = 32'h5;
    i_b     = 32'h6;
    step();
    i_valid = 1'b0;
    i_flush = 1'b0;
    check("flush_vs_valid", {o_busy, o_ready}, 2'b01);

    // Flush at CALC count 10: one cycle after accept is count 0.
    i_valid = 1'b1;
    i_op    = 2'b11;
    i_a     = 32'h1234_0000;
    i_b     = 32'h0000_ABCD;
    step();
    i_valid = 1'b0;
    repeat (10) step();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    check("flush_calc", {o_valid, o_busy, o_ready}, 3'b001);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (o_valid) seen++;
      step();
    end
    check("flush_no_valid", seen, 0);
    do_op("mulhu_3x5", 2'b11, 32'h0000_0003, 32'h0000_0005, 0);

    do_op("mul_zero", 2'b00, 32'h0000_0000, 32'hDEAD_BEEF, 0);
    do_op("mul_7x9",  2'b00, 32'h0000_0007, 32'h0000_0009, 0);

    // Flush in DONE beats i_ready and drops the result.
    i_valid = 1'b1;
    i_op    = 2'b11;
    i_a     = 32'hFFFF_0000;
    i_b     = 32'h0001_0000;
    step();
    i_valid = 1'b0;
    wait_valid(cyc);
    check("done_reached", o_valid, 1'b1);
    i_flush = 1'b1;
    i_ready = 1'b1;
    step();
    i_flush = 1'b0;
    i_ready = 1'b0;
    check("flush_done", {o_valid, o_busy, o_ready}, 3'b001);
    check("flush_keeps_res", o_result, 32'h0000_FFFF);

    // Reset mid-operation also clears o_result.
    i_valid = 1'b1;
    i_op    = 2'b01;
    i_a     = 32'h8765_4321;
    i_b     = 32'h1111_1111;
    step();
    i_valid = 1'b0;
    repeat (5) step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check("rst_mid", {o_valid, o_busy, o_ready, o_result}, {3'b001, 32'h0});

    do_op("mulhsu_neg", 2'b10, 32'hFFFF_FFFE, 32'h0000_0003, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
